multicycle_sequencer: RTL and testbench

Multi-cycle control unit for the RV32I datapath. It fetches instructions over a request/valid instruction bus and holds the current instruction for the datapath. It decodes the instruction and drives the datapath control inputs, then commits the register-file and PC updates in exactly one cycle per instruction. It also sequences data-memory accesses with wait states and a timeout, and halts in a trap state on illegal opcodes or bus timeout.

---
 rtl/core_ctrl_pkg.sv | 49 ++++
 rtl/control_decoder.sv | 96 +++++++++
 rtl/multicycle_sequencer.sv | 130 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, opcodes,
// ALU codes and the PCSrc / MemtoReg / trap_cause field values.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JAL    = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_LOAD = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
  localparam logic [1:0] M2R_IMM  = 2'b11;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM_TO = 2'b10;
  localparam logic [1:0] TRAP_DMEM_TO = 2'b11;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: is_legal_opcode = 1'b1;
      default:                                is_legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational datapath-control decode from the current FSM state and the
// latched instruction fields.
module control_decoder
  import core_ctrl_pkg::*;
(
  input  logic [2:0] i_state,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_b5,
  input  logic       i_branch_taken,
  input  logic       i_dmem_rvalid,
  output logic       o_imem_req,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic [4:0] o_alu_control,
  output logic       o_branch,
  output logic [1:0] o_pc_src,
  output logic [1:0] o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_pc_en
);

  state_t w_state;
  assign w_state = state_t'(i_state);

  always_comb begin
    o_imem_req    = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 1'b0;
    o_alu_control = ALU_ADD;
    o_branch      = 1'b0;
    o_pc_src      = PCSRC_PC4;
    o_mem_to_reg  = M2R_ALU;
    o_reg_write   = 1'b0;
    o_pc_en       = 1'b0;

    o_imem_req = (w_state == ST_FETCH);

    // ALU operand selection stays asserted through MEM so the address is stable.
    if (w_state == ST_EXEC || w_state == ST_MEM) begin
      case (i_opcode)
        OPC_OP:    o_alu_control = {1'b0, i_funct7_b5, i_funct3};
        OPC_OPIMM: begin
          o_alu_src_b   = 1'b1;
          o_alu_control = {1'b0, (i_funct3 == 3'b101) ? i_funct7_b5 : 1'b0, i_funct3};
        end
        OPC_LOAD, OPC_STORE, OPC_JALR: o_alu_src_b = 1'b1;
        OPC_AUIPC: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 1'b1;
        end
        OPC_BRANCH: o_alu_control = ALU_SUB;
        default:    o_alu_control = ALU_ADD;
      endcase
    end

    if (w_state == ST_EXEC) begin
      case (i_opcode)
        OPC_LOAD, OPC_STORE: ;
        OPC_BRANCH: begin
          o_branch = 1'b1;
          o_pc_src = i_branch_taken ? PCSRC_BRANCH : PCSRC_PC4;
          o_pc_en  = 1'b1;
        end
        default: begin
          o_pc_en     = 1'b1;
          o_reg_write = 1'b1;
          if (i_opcode == OPC_JAL) begin
            o_pc_src     = PCSRC_JAL;
            o_mem_to_reg = M2R_PC4;
          end else if (i_opcode == OPC_JALR) begin
            o_pc_src     = PCSRC_JALR;
            o_mem_to_reg = M2R_PC4;
          end else if (i_opcode == OPC_LUI) begin
            o_mem_to_reg = M2R_IMM;
          end
        end
      endcase
    end

    if (w_state == ST_MEM) begin
      o_dmem_req = 1'b1;
      o_dmem_we  = (i_opcode == OPC_STORE);
      if (i_opcode == OPC_LOAD) o_mem_to_reg = M2R_LOAD;
      if (i_dmem_rvalid) begin
        o_pc_en     = 1'b1;
        o_reg_write = (i_opcode == OPC_LOAD);
      end
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// RV32I multi-cycle control FSM: instruction fetch/latch, bus wait counting with
// timeout, and trap handling; datapath controls come from control_decoder.
module multicycle_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int          TIMEOUT_W   = 8,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_rvalid,
  input  logic        branch_taken,
  output logic [31:0] instr_reg,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic [4:0]  ALUControl,
  output logic        Branch,
  output logic [1:0]  PCSrc,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic        pc_en,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  state_t                 r_state, w_state_next;
  logic [31:0]            r_instr, w_instr_next;
  logic [TIMEOUT_W-1:0]   r_wait, w_wait_next;
  logic [1:0]             r_trap_cause, w_trap_cause_next;
  logic                   w_timeout;
  logic                   w_imem_req, w_dmem_req, w_dmem_we, w_reg_write, w_pc_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FETCH;
      r_instr      <= NOP_INSTR;
      r_wait       <= '0;
      r_trap_cause <= TRAP_NONE;
    end else begin
      r_state      <= w_state_next;
      r_instr      <= w_instr_next;
      r_wait       <= w_wait_next;
      r_trap_cause <= w_trap_cause_next;
    end
  end

  // The wait that would bring the counter to TIMEOUT_CYC traps instead.
  assign w_timeout = (r_wait == TIMEOUT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_next      = r_state;
    w_instr_next      = r_instr;
    w_trap_cause_next = r_trap_cause;
    w_wait_next       = '0;

    case (r_state)
      ST_FETCH: begin
        if (imem_rvalid) begin
          w_instr_next = imem_rdata;
          w_state_next = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = TRAP_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(r_instr[6:0])) begin
          w_state_next = ST_EXEC;
        end else begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (r_instr[6:0] == OPC_LOAD || r_instr[6:0] == OPC_STORE) w_state_next = ST_MEM;
        else                                                       w_state_next = ST_FETCH;
      end
      ST_MEM: begin
        if (dmem_rvalid) begin
          w_state_next = ST_FETCH;
        end else if (w_timeout) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = TRAP_DMEM_TO;
        end
      end
      ST_TRAP: w_state_next = ST_TRAP;
      default: w_state_next = ST_FETCH;
    endcase

    if (w_state_next == r_state && (r_state == ST_FETCH || r_state == ST_MEM))
      w_wait_next = r_wait + TIMEOUT_W'(1);
  end

  control_decoder u_control_decoder (
    .i_state        (r_state),
    .i_opcode       (r_instr[6:0]),
    .i_funct3       (r_instr[14:12]),
    .i_funct7_b5    (r_instr[30]),
    .i_branch_taken (branch_taken),
    .i_dmem_rvalid  (dmem_rvalid),
    .o_imem_req     (w_imem_req),
    .o_dmem_req     (w_dmem_req),
    .o_dmem_we      (w_dmem_we),
    .o_alu_src_a    (ALUSrc_A),
    .o_alu_src_b    (ALUSrc_B),
    .o_alu_control  (ALUControl),
    .o_branch       (Branch),
    .o_pc_src       (PCSrc),
    .o_mem_to_reg   (MemtoReg),
    .o_reg_write    (w_reg_write),
    .o_pc_en        (w_pc_en)
  );

  // Requests and strobes are forced low while reset is held, even mid-transaction.
  assign imem_req   = rst & w_imem_req;
  assign dmem_req   = rst & w_dmem_req;
  assign dmem_we    = rst & w_dmem_we;
  assign RegWrite   = rst & w_reg_write;
  assign pc_en      = rst & w_pc_en;
  assign instr_reg  = r_instr;
  assign halted     = (r_state == ST_TRAP);
  assign trap_cause = r_trap_cause;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer: reset, ALU/jump decode, load wait
// states, branches, illegal opcode and bus timeouts.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_rvalid = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] instr_reg;
  logic        ALUSrc_A, ALUSrc_B, Branch, RegWrite, pc_en, halted;
  logic [4:0]  ALUControl;
  logic [1:0]  PCSrc, MemtoReg, trap_cause;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rvalid(dmem_rvalid),
    .branch_taken(branch_taken), .instr_reg(instr_reg),
    .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALUControl(ALUControl),
    .Branch(Branch), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .pc_en(pc_en), .halted(halted), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        src_a;
    logic        src_b;
    logic [4:0]  alu;
    logic        chk_alu;
    logic [1:0]  pcsrc;
    logic [1:0]  m2r;
  } exp_t;

  // Each cycle starts 1 time unit after the rising edge; inputs are driven then
  // and outputs checked one unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b0; dmem_rvalid = 1'b0; branch_taken = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    n_tests++; if (instr_reg !== 32'h00000013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instr_reg); end
    n_tests++; if (halted !== 1'b0 || trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_trap: got %b/%b want 0/00", halted, trap_cause); end
    rst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000A103;
    #1;
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL release_imem_req: got %b want 1", imem_req); end
    tick(); imem_rvalid = 1'b0;
    tick();
    tick(); #1;
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mid_mem_dmem_req: got %b want 1", dmem_req); end
    rst = 1'b0; #1;
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_drops_dmem_req: got %b want 0", dmem_req); end
    n_tests++; if (instr_reg !== 32'h00000013) begin n_fail++; $display("FAIL reset_mid_instr: got %h want 00000013", instr_reg); end
    tick(); rst = 1'b1; #1;
    n_tests++; if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL after_release: got imem %b dmem %b want 1 0", imem_req, dmem_req); end
    $display("[TB] reset: mid-MEM reset checked");
  endtask

  task automatic test_alu_jump();
    exp_t v[9];
    int   commits = 0;
    int   cycles = 0;
    v[0] = '{32'h00500093, 1'b0, 1'b1, 5'b00000, 1'b1, 2'b00, 2'b00}; // addi x1,x0,5
    v[1] = '{32'h402081B3, 1'b0, 1'b0, 5'b01000, 1'b1, 2'b00, 2'b00}; // sub
    v[2] = '{32'h4030D093, 1'b0, 1'b1, 5'b01101, 1'b1, 2'b00, 2'b00}; // srai
    v[3] = '{32'h0020E1B3, 1'b0, 1'b0, 5'b00110, 1'b1, 2'b00, 2'b00}; // or
    v[4] = '{32'hC0000093, 1'b0, 1'b1, 5'b00000, 1'b1, 2'b00, 2'b00}; // addi with imm bit30 set
    v[5] = '{32'h123452B7, 1'b0, 1'b0, 5'b00000, 1'b0, 2'b00, 2'b11}; // lui
    v[6] = '{32'h00001117, 1'b1, 1'b1, 5'b00000, 1'b1, 2'b00, 2'b00}; // auipc
    v[7] = '{32'h000000EF, 1'b0, 1'b0, 5'b00000, 1'b1, 2'b10, 2'b10}; // jal
    v[8] = '{32'h00008067, 1'b0, 1'b1, 5'b00000, 1'b1, 2'b11, 2'b10}; // jalr
    do_reset();
    for (int i = 0; i < 9; i++) begin
      imem_rvalid = 1'b1; imem_rdata = v[i].instr; #1;
      n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL alu%0d_fetch: imem_req got %b want 1", i, imem_req); end
      if (pc_en === 1'b1) commits++;
      cycles++;
      tick(); imem_rvalid = 1'b0; #1;
      n_tests++; if (pc_en !== 1'b0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu%0d_decode: pc_en %b RegWrite %b want 0 0", i, pc_en, RegWrite); end
      if (pc_en === 1'b1) commits++;
      cycles++;
      tick(); #1;
      n_tests++;
      if (ALUSrc_A !== v[i].src_a || ALUSrc_B !== v[i].src_b || (v[i].chk_alu && ALUControl !== v[i].alu) ||
          PCSrc !== v[i].pcsrc || MemtoReg !== v[i].m2r || RegWrite !== 1'b1 || pc_en !== 1'b1 || Branch !== 1'b0) begin
        n_fail++;
        $display("FAIL alu%0d_exec %h: got A%b B%b alu %b pc %b m2r %b rw %b pe %b br %b want A%b B%b alu %b pc %b m2r %b rw 1 pe 1 br 0",
                 i, v[i].instr, ALUSrc_A, ALUSrc_B, ALUControl, PCSrc, MemtoReg, RegWrite, pc_en, Branch,
                 v[i].src_a, v[i].src_b, v[i].alu, v[i].pcsrc, v[i].m2r);
      end
      if (pc_en === 1'b1) commits++;
      cycles++;
      tick();
      $display("[TB] alu/jump %h retired", v[i].instr);
    end
    n_tests++; if (commits != 9) begin n_fail++; $display("FAIL back_to_back_commits: got %0d want 9 in %0d cycles", commits, cycles); end
  endtask

  task automatic test_load_wait();
    int req_cycles = 0;
    int commits = 0;
    do_reset();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000A103;
    tick(); imem_rvalid = 1'b0;
    tick(); #1;
    n_tests++; if (dmem_req !== 1'b0 || pc_en !== 1'b0 || RegWrite !== 1'b0 || ALUSrc_B !== 1'b1 || ALUControl !== 5'b00000) begin
      n_fail++; $display("FAIL lw_exec: dmem_req %b pc_en %b rw %b B %b alu %b want 0 0 0 1 00000", dmem_req, pc_en, RegWrite, ALUSrc_B, ALUControl); end
    tick();
    for (int i = 0; i < 5; i++) begin
      dmem_rvalid = (i == 4); #1;
      if (dmem_req === 1'b1) req_cycles++;
      if (pc_en === 1'b1) commits++;
      n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL lw_dmem_we: got %b want 0", dmem_we); end
      if (i == 4) begin
        n_tests++; if (RegWrite !== 1'b1 || MemtoReg !== 2'b01 || pc_en !== 1'b1) begin
          n_fail++; $display("FAIL lw_commit: rw %b m2r %b pe %b want 1 01 1", RegWrite, MemtoReg, pc_en); end
      end
      tick();
    end
    dmem_rvalid = 1'b0; #1;
    if (dmem_req === 1'b1) req_cycles++;
    n_tests++; if (req_cycles != 5 || commits != 1) begin n_fail++; $display("FAIL lw_wait: dmem_req cycles %0d commits %0d want 5 1", req_cycles, commits); end
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL lw_refetch: imem_req got %b want 1", imem_req); end
    $display("[TB] lw with 4 wait states: dmem_req %0d cycles", req_cycles);
  endtask

  task automatic test_branch();
    logic [1:0] exp_pc;
    do_reset();
    for (int t = 1; t >= 0; t--) begin
      imem_rvalid = 1'b1; imem_rdata = 32'h00000463;
      tick(); imem_rvalid = 1'b0;
      tick(); branch_taken = (t == 1); #1;
      exp_pc = (t == 1) ? 2'b01 : 2'b00;
      n_tests++; if (PCSrc !== exp_pc || Branch !== 1'b1 || ALUControl !== 5'b01000 || RegWrite !== 1'b0 || pc_en !== 1'b1) begin
        n_fail++; $display("FAIL beq_taken%0d: pc %b br %b alu %b rw %b pe %b want %b 1 01000 0 1", t, PCSrc, Branch, ALUControl, RegWrite, pc_en, exp_pc); end
      tick(); branch_taken = 1'b0;
      $display("[TB] beq taken=%0d PCSrc=%b", t, exp_pc);
    end
  endtask

  task automatic test_illegal();
    int reqs = 0;
    int commits = 0;
    do_reset();
    imem_rvalid = 1'b1; imem_rdata = 32'h00000000;
    tick(); imem_rvalid = 1'b0;
    tick(); #1;
    n_tests++; if (halted !== 1'b1 || trap_cause !== 2'b01) begin n_fail++; $display("FAIL illegal_trap: halted %b cause %b want 1 01", halted, trap_cause); end
    for (int i = 0; i < 10; i++) begin
      imem_rvalid = 1'b1; dmem_rvalid = 1'b1; #1;
      if (imem_req === 1'b1) reqs++;
      if (pc_en === 1'b1) commits++;
      tick();
    end
    imem_rvalid = 1'b0; dmem_rvalid = 1'b0;
    n_tests++; if (reqs != 0 || commits != 0 || halted !== 1'b1) begin n_fail++; $display("FAIL illegal_hold: reqs %0d commits %0d halted %b want 0 0 1", reqs, commits, halted); end
    $display("[TB] illegal opcode trapped, cause %b", trap_cause);
  endtask

  task automatic test_imem_timeout();
    int reqs = 0;
    do_reset();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (halted === 1'b1) break;
      if (imem_req === 1'b1) reqs++;
      tick();
    end
    n_tests++; if (reqs != 255 || halted !== 1'b1 || trap_cause !== 2'b10) begin
      n_fail++; $display("FAIL imem_timeout: req cycles %0d halted %b cause %b want 255 1 10", reqs, halted, trap_cause); end
    $display("[TB] imem timeout after %0d request cycles", reqs);
  endtask

  task automatic test_store_timeout();
    int reqs = 0;
    int commits = 0;
    int bad_we = 0;
    do_reset();
    imem_rvalid = 1'b1; imem_rdata = 32'h0020A223;
    tick(); imem_rvalid = 1'b0;
    tick(); #1;
    n_tests++; if (dmem_req !== 1'b0 || pc_en !== 1'b0 || ALUSrc_B !== 1'b1) begin
      n_fail++; $display("FAIL sw_exec: dmem_req %b pc_en %b B %b want 0 0 1", dmem_req, pc_en, ALUSrc_B); end
    tick();
    for (int i = 0; i < 400; i++) begin
      imem_rvalid = 1'b1; #1;
      if (halted === 1'b1) break;
      if (dmem_req === 1'b1) reqs++;
      if (dmem_we !== 1'b1) bad_we++;
      if (pc_en === 1'b1) commits++;
      tick();
    end
    imem_rvalid = 1'b0;
    n_tests++; if (reqs != 255 || bad_we != 0 || commits != 0) begin
      n_fail++; $display("FAIL sw_timeout_mem: req cycles %0d bad_we %0d commits %0d want 255 0 0", reqs, bad_we, commits); end
    n_tests++; if (halted !== 1'b1 || trap_cause !== 2'b11 || pc_en !== 1'b0) begin
      n_fail++; $display("FAIL sw_timeout_trap: halted %b cause %b pc_en %b want 1 11 0", halted, trap_cause, pc_en); end
    $display("[TB] sw dmem timeout after %0d request cycles", reqs);
  endtask

  initial begin
    test_reset();
    test_alu_jump();
    test_load_wait();
    test_branch();
    test_illegal();
    test_imem_timeout();
    test_store_timeout();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
